// File: rtl/stepper_pkg.sv
// stepper_pkg: shared FSM state type, minimum step period and default widths for the step generator
package stepper_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_e;
  localparam int MIN_PERIOD = 2;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_PER_W = 16;
  localparam int DEF_SETUP_CYC = 4;
  localparam int DEF_POS_W = 32;
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter; tick_o marks the last cycle of a loaded interval
module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PER_W-1:0] load_val_i,
  output logic             tick_o
);
  logic [PER_W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - PER_W'(1);
  assign tick_o = cnt_q == PER_W'(1);
endmodule

// File: rtl/stepper_step_gen.sv
// stepper_step_gen: command-driven step/dir pulse generator feeding drv8835_if.
// Define STEP_POS_EN to add the signed position counter (pos, pos_clr).
module stepper_step_gen
  import stepper_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PER_W = DEF_PER_W,
  parameter int SETUP_CYC = DEF_SETUP_CYC
`ifdef STEP_POS_EN
  , parameter int POS_W = DEF_POS_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             hold_en,
  output logic             en,
  output logic             dir,
  output logic             step,
  output logic             busy,
  output logic             done,
  output logic             aborted
`ifdef STEP_POS_EN
  , input  logic                    pos_clr,
  output logic signed [POS_W-1:0] pos
`endif
);
  state_e state_q;
  logic cmd_ready_q, en_q, dir_q, step_q, busy_q, done_q, aborted_q;
  logic [CNT_W-1:0] rem_q;
  logic [PER_W-1:0] per_q;
  logic accept, running, tick, tmr_load;
  assign accept = cmd_valid & cmd_ready_q;
  assign running = (state_q == SETUP) || (state_q == RUN);
  assign tmr_load = accept | (tick & running);
  step_timer #(.PER_W(PER_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load_i(tmr_load),
    .load_val_i(accept ? PER_W'(SETUP_CYC) : per_q),
    .tick_o(tick)
  );
  // One timer serves both the setup delay and the step period; a tick with no steps left ends the move
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_ready_q <= 1'b0;
      en_q <= 1'b0;
      dir_q <= 1'b0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      rem_q <= '0;
      per_q <= PER_W'(MIN_PERIOD);
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          en_q <= hold_en;
          busy_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            busy_q <= 1'b1;
            rem_q <= cmd_steps;
            per_q <= (cmd_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : cmd_period;
            if (cmd_steps == '0) begin
              state_q <= DONE;
              done_q <= 1'b1;
            end else begin
              state_q <= SETUP;
              en_q <= 1'b1;
              dir_q <= cmd_dir;
            end
          end
        end
        SETUP, RUN: begin
          if (abort) begin
            state_q <= DONE;
            aborted_q <= 1'b1;
          end else if (tick) begin
            if (rem_q != '0) begin
              step_q <= 1'b1;
              rem_q <= rem_q - CNT_W'(1);
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          en_q <= hold_en;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign en = en_q;
  assign dir = dir_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;
  assign aborted = aborted_q;
`ifdef STEP_POS_EN
  logic signed [POS_W-1:0] pos_q;
  always_ff @(posedge clk)
    if (rst || pos_clr) pos_q <= '0;
    else if (step_q) pos_q <= dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
  assign pos = pos_q;
`endif
endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: randomized and directed checks of stepper_step_gen against a timing model
module tb_stepper_step_gen;
  localparam int CNT_W = 16;
  localparam int PER_W = 16;
  localparam int SC = 4;
  localparam int TR = 8192;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0, hold_en = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [PER_W-1:0] cmd_period = '0;
  logic cmd_ready, en, dir, step, busy, done, aborted;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic en_tr [TR];
  logic dir_tr [TR];
  logic busy_tr [TR];
  logic rdy_tr [TR];
  int step_log[$], done_log[$], abt_log[$], acc_log[$], exp_q[$];
`ifdef STEP_POS_EN
  logic pos_clr = 1'b0;
  logic signed [31:0] pos;
  int pos_tr [TR];
`endif

  stepper_step_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort), .hold_en(hold_en),
    .en(en), .dir(dir), .step(step), .busy(busy), .done(done), .aborted(aborted)
`ifdef STEP_POS_EN
    , .pos_clr(pos_clr), .pos(pos)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cyc < TR) begin
    en_tr[cyc] = en;
    dir_tr[cyc] = dir;
    busy_tr[cyc] = busy;
    rdy_tr[cyc] = cmd_ready;
`ifdef STEP_POS_EN
    pos_tr[cyc] = pos;
`endif
    if (step) step_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
    if (aborted) abt_log.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_log.push_back(cyc);
  end

  function automatic int eff(input int p);
    return p < 2 ? 2 : p;
  endfunction
  function automatic int fin(input int k, input int n, input int p);
    return n == 0 ? k + 1 : k + 1 + SC + n * eff(p);
  endfunction
  function automatic void build(input int k, input int n, input int p, input int lim);
    for (int i = 0; i < n; i++) if (k + 1 + SC + i * eff(p) <= lim) exp_q.push_back(k + 1 + SC + i * eff(p));
  endfunction
  function automatic void clear_logs();
    step_log.delete(); done_log.delete(); abt_log.delete(); acc_log.delete(); exp_q.delete();
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask
  task automatic issue(input logic d, input int n, input int p, input bit keep, output int k);
    int w;
    w = 0; k = -1;
    cmd_dir = d; cmd_steps = CNT_W'(n); cmd_period = PER_W'(p); cmd_valid = 1'b1;
    while (k < 0 && w < 200) begin
      @(negedge clk);
      if (cmd_ready) k = cyc;
      @(posedge clk); #1;
      w++;
    end
    if (!keep) cmd_valid = 1'b0;
    n_chk++;
    if (k < 0) begin n_fail++; $display("FAIL handshake: got no accept, required accept within 200 cycles"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if ({en, dir, step, busy, done, aborted, cmd_ready} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs: got %b, required 0000000", {en, dir, step, busy, done, aborted, cmd_ready});
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_early: got %b, required 0", cmd_ready); end
    tick();
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b, required 1", cmd_ready); end
    tick();
  endtask

  task automatic test_forward();
    int k, e;
    clear_logs(); hold_en = 1'b0;
    issue(1'b0, 4, 10, 1'b0, k);
    e = fin(k, 4, 10);
    wait_to(e + 3);
    build(k, 4, 10, e);
    n_chk++;
    if (step_log.size() != exp_q.size()) begin n_fail++; $display("FAIL fwd_count: got %0d pulses, required %0d", step_log.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= step_log.size() || step_log[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL fwd_step%0d: got cycle %0d, required %0d", i, i < step_log.size() ? step_log[i] : -1, exp_q[i]);
      end
    end
    n_chk++;
    if (done_log.size() != 1 || done_log[0] !== e) begin n_fail++; $display("FAIL fwd_done: got %0d pulses (first %0d), required one at %0d", done_log.size(), done_log.size() ? done_log[0] : -1, e); end
    n_chk++;
    if (abt_log.size() != 0) begin n_fail++; $display("FAIL fwd_aborted: got %0d pulses, required 0", abt_log.size()); end
    for (int c = k + 1; c <= e; c++) begin
      n_chk++;
      if (en_tr[c] !== 1'b1 || dir_tr[c] !== 1'b0) begin n_fail++; $display("FAIL fwd_en_dir@%0d: got en=%b dir=%b, required en=1 dir=0", c, en_tr[c], dir_tr[c]); end
    end
    n_chk++;
    if (rdy_tr[e + 1] !== 1'b1 || busy_tr[e + 1] !== 1'b0) begin n_fail++; $display("FAIL fwd_idle: got ready=%b busy=%b, required 1 0", rdy_tr[e + 1], busy_tr[e + 1]); end
  endtask

  task automatic test_zero();
    int k;
    clear_logs();
    issue(1'b1, 0, 7, 1'b0, k);
    wait_to(k + 6);
    n_chk++;
    if (step_log.size() != 0) begin n_fail++; $display("FAIL zero_steps: got %0d pulses, required 0", step_log.size()); end
    n_chk++;
    if (done_log.size() != 1 || done_log[0] !== k + 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses (first %0d), required one at %0d", done_log.size(), done_log.size() ? done_log[0] : -1, k + 1); end
    n_chk++;
    if ({busy_tr[k], busy_tr[k + 1], busy_tr[k + 2]} !== 3'b010) begin n_fail++; $display("FAIL zero_busy: got %b, required 010", {busy_tr[k], busy_tr[k + 1], busy_tr[k + 2]}); end
    n_chk++;
    if (rdy_tr[k + 2] !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b, required 1", rdy_tr[k + 2]); end
  endtask

  task automatic test_clamp();
    int k, e;
    for (int p = 0; p < 2; p++) begin
      clear_logs();
      issue(1'b0, 3, p, 1'b0, k);
      e = fin(k, 3, p);
      wait_to(e + 3);
      build(k, 3, p, e);
      n_chk++;
      if (step_log.size() != exp_q.size()) begin n_fail++; $display("FAIL clamp%0d_count: got %0d pulses, required %0d", p, step_log.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_chk++;
        if (i >= step_log.size() || step_log[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL clamp%0d_step%0d: got cycle %0d, required %0d", p, i, i < step_log.size() ? step_log[i] : -1, exp_q[i]);
        end
      end
      n_chk++;
      if (done_log.size() != 1 || done_log[0] !== e) begin n_fail++; $display("FAIL clamp%0d_done: got first %0d, required %0d", p, done_log.size() ? done_log[0] : -1, e); end
    end
  endtask

  task automatic test_abort();
    int k, n;
    clear_logs(); hold_en = 1'b0;
    issue(1'b0, 8, 6, 1'b0, k);
    wait_to(k + 1 + SC + eff(6) + 1);
    n = cyc;
    abort = 1'b1; tick(); abort = 1'b0;
    wait_to(n + 8);
    build(k, 8, 6, n);
    n_chk++;
    if (step_log.size() != 2 || exp_q.size() != 2) begin n_fail++; $display("FAIL abort_count: got %0d pulses, required 2", step_log.size()); end
    n_chk++;
    if (abt_log.size() != 1 || abt_log[0] !== n + 1) begin n_fail++; $display("FAIL abort_pulse: got %0d pulses (first %0d), required one at %0d", abt_log.size(), abt_log.size() ? abt_log[0] : -1, n + 1); end
    n_chk++;
    if (done_log.size() != 0) begin n_fail++; $display("FAIL abort_done: got %0d done pulses, required 0", done_log.size()); end
    n_chk++;
    if ({rdy_tr[n + 1], rdy_tr[n + 2]} !== 2'b01) begin n_fail++; $display("FAIL abort_ready: got %b, required 01", {rdy_tr[n + 1], rdy_tr[n + 2]}); end
    n_chk++;
    if ({en_tr[n + 1], en_tr[n + 2]} !== 2'b10) begin n_fail++; $display("FAIL abort_en: got %b, required 10", {en_tr[n + 1], en_tr[n + 2]}); end
  endtask

  task automatic test_reset_mid();
    int k, r, k2, e2;
    clear_logs(); hold_en = 1'b1;
    issue(1'b1, 6, 5, 1'b0, k);
    wait_to(k + 1 + SC + 2);
    r = cyc;
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({en, dir, step, busy, done, aborted, cmd_ready} !== 7'b0) begin
      n_fail++; $display("FAIL rstmid_outs: got %b, required 0000000", {en, dir, step, busy, done, aborted, cmd_ready});
    end
    wait_to(r + 40);
    n_chk++;
    if (step_log.size() != 1 || step_log[0] !== k + 1 + SC) begin n_fail++; $display("FAIL rstmid_steps: got %0d pulses, required 1 at %0d", step_log.size(), k + 1 + SC); end
    hold_en = 1'b0;
    issue(1'b0, 2, 3, 1'b0, k2);
    e2 = fin(k2, 2, 3);
    wait_to(e2 + 2);
    n_chk++;
    if (done_log.size() != 1 || done_log[0] !== e2) begin n_fail++; $display("FAIL rstmid_newcmd: got done at %0d, required %0d", done_log.size() ? done_log[0] : -1, e2); end
  endtask

  task automatic test_back_to_back();
    int k1, k2, e1, e2;
    clear_logs();
    issue(1'b0, 4, 4, 1'b1, k1);
    e1 = fin(k1, 4, 4);
    issue(1'b1, 4, 4, 1'b0, k2);
    e2 = fin(k2, 4, 4);
    wait_to(e2 + 3);
    n_chk++;
    if (k2 !== e1 + 1) begin n_fail++; $display("FAIL b2b_accept: got cycle %0d, required %0d", k2, e1 + 1); end
    n_chk++;
    if (acc_log.size() != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d accepts, required 2", acc_log.size()); end
    build(k1, 4, 4, e1);
    build(e1 + 1, 4, 4, fin(e1 + 1, 4, 4));
    n_chk++;
    if (step_log.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, required %0d", step_log.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_chk++;
      if (i >= step_log.size() || step_log[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_step%0d: got cycle %0d, required %0d", i, i < step_log.size() ? step_log[i] : -1, exp_q[i]);
      end
    end
    n_chk++;
    if (dir_tr[e1] !== 1'b0 || dir_tr[e1 + 1 + 1 + SC] !== 1'b1) begin n_fail++; $display("FAIL b2b_dir: got %b then %b, required 0 then 1", dir_tr[e1], dir_tr[e1 + 2 + SC]); end
`ifdef STEP_POS_EN
    begin
      int k3, s2, e3;
      n_chk++;
      if (pos_tr[e1 + 1] !== 4 || pos_tr[e2 + 1] !== 0) begin n_fail++; $display("FAIL b2b_pos: got %0d then %0d, required 4 then 0", pos_tr[e1 + 1], pos_tr[e2 + 1]); end
      issue(1'b0, 3, 4, 1'b0, k3);
      s2 = k3 + 1 + SC + 4;
      e3 = fin(k3, 3, 4);
      wait_to(s2);
      pos_clr = 1'b1; tick(); pos_clr = 1'b0;
      wait_to(e3 + 2);
      n_chk++;
      if (pos !== 1) begin n_fail++; $display("FAIL pos_clr: got %0d, required 1", pos); end
    end
`endif
  endtask

  task automatic test_random();
    int k, e, n, p, a, c;
    logic d, h;
    bit ab;
    for (int it = 0; it < 8; it++) begin
      d = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 5);
      p = $urandom_range(0, 9);
      ab = (n > 0) && ($urandom_range(0, 1) == 1);
      clear_logs(); hold_en = h;
      issue(d, n, p, 1'b0, k);
      e = fin(k, n, p);
      a = ab ? k + 1 + int'($urandom_range(0, e - k - 2)) : e;
      if (ab) begin
        wait_to(a);
        abort = 1'b1; tick(); abort = 1'b0;
      end
      c = ab ? a + 1 : e;
      build(k, n, p, ab ? a : e);
      wait_to(c + 3);
      n_chk++;
      if (step_log.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d pulses, required %0d", it, step_log.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_chk++;
        if (i >= step_log.size() || step_log[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rnd%0d_step%0d: got cycle %0d, required %0d", it, i, i < step_log.size() ? step_log[i] : -1, exp_q[i]);
        end
      end
      n_chk++;
      if (ab ? (abt_log.size() != 1 || abt_log[0] !== c || done_log.size() != 0)
             : (done_log.size() != 1 || done_log[0] !== c || abt_log.size() != 0)) begin
        n_fail++; $display("FAIL rnd%0d_end: got done=%0d aborted=%0d pulses, required one %s at %0d", it, done_log.size(), abt_log.size(), ab ? "aborted" : "done", c);
      end
      n_chk++;
      if (rdy_tr[c + 1] !== 1'b1 || en_tr[c + 1] !== h) begin n_fail++; $display("FAIL rnd%0d_idle: got ready=%b en=%b, required 1 %b", it, rdy_tr[c + 1], en_tr[c + 1], h); end
      if (n > 0) begin
        n_chk++;
        if (dir_tr[k + 1] !== d) begin n_fail++; $display("FAIL rnd%0d_dir: got %b, required %b", it, dir_tr[k + 1], d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero();
    test_clamp();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
